tmr_counter_ctrl: RTL and testbench

Triple-modular-redundant up/down counter with parametrised width and modulus, synchronous load, per-cycle scrubbing of all replicas, and fault logging. Three replica registers feed a bitwise majority voter. The voted value drives the output and is the single source for the next state. Replica disagreements are recorded in sticky per-replica flags and a saturating event counter, and an injection port supports fault campaigns. It is the next generation of the team's TMR counter for use in radiation-tolerant control paths.

---
 rtl/tmr_counter_ctrl.sv | 108 ++++++++++
 tb/tb_tmr_counter_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/tmr_counter_ctrl.sv
// Triple-modular-redundant up/down counter with modulus, synchronous load,
// per-edge scrubbing of all replicas from the voted value, and fault logging.
module tmr_counter_ctrl #(
    parameter int unsigned      WIDTH   = 64,
    parameter logic [WIDTH-1:0] MODULUS = '0,
    parameter int unsigned      FCNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              up,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              clr_faults,
    input  logic [2:0]        inj,
    input  logic [WIDTH-1:0]  inj_mask,
    output logic [WIDTH-1:0]  q_out,
    output logic              tc,
    output logic [2:0]        mismatch,
    output logic [2:0]        fault_vec,
    output logic [FCNT_W-1:0] fault_cnt,
    output logic              uncorrectable
);

    localparam logic [WIDTH-1:0]  ONE  = WIDTH'(1);
    localparam logic [FCNT_W-1:0] FONE = FCNT_W'(1);
    // MODULUS of 0 selects the natural 2^WIDTH wrap.
    localparam logic [WIDTH-1:0]  LAST = (MODULUS == '0) ? '1 : MODULUS - ONE;

    logic [WIDTH-1:0]  r0_q, r1_q, r2_q;
    logic [WIDTH-1:0]  r0_d, r1_d, r2_d;
    logic [WIDTH-1:0]  v;
    logic [WIDTH-1:0]  nxt;
    logic              any_mismatch;
    logic              all_distinct;
    logic [2:0]        fault_vec_q, fault_vec_d;
    logic [FCNT_W-1:0] fault_cnt_q, fault_cnt_d;
    logic [FCNT_W-1:0] cnt_base;
    logic              uncorr_q, uncorr_d;

    // Bitwise majority vote and per-replica disagreement detection.
    always_comb begin
        v            = (r0_q & r1_q) | (r0_q & r2_q) | (r1_q & r2_q);
        mismatch     = {r2_q != v, r1_q != v, r0_q != v};
        any_mismatch = |mismatch;
        all_distinct = (r0_q != r1_q) && (r0_q != r2_q) && (r1_q != r2_q);
        q_out        = v;
        tc           = enable & ~load & ((up & (v == LAST)) | (~up & (v == '0)));
    end

    // Next count from the voted value: load (clamped), step up/down with wrap, or hold.
    always_comb begin
        nxt = v;
        if (load) begin
            nxt = (load_val > LAST) ? LAST : load_val;
        end else if (enable && up) begin
            nxt = (v == LAST) ? '0 : v + ONE;
        end else if (enable) begin
            nxt = (v == '0) ? LAST : v - ONE;
        end
    end

    // Every replica is rewritten each edge; injection flips bits of selected replicas only.
    always_comb begin
        r0_d = nxt ^ (inj[0] ? inj_mask : '0);
        r1_d = nxt ^ (inj[1] ? inj_mask : '0);
        r2_d = nxt ^ (inj[2] ? inj_mask : '0);
    end

    // Fault log next state; a new event in the clearing cycle is still recorded.
    always_comb begin
        cnt_base    = clr_faults ? '0 : fault_cnt_q;
        fault_cnt_d = (any_mismatch && (cnt_base != '1)) ? cnt_base + FONE : cnt_base;
        fault_vec_d = (clr_faults ? 3'b000 : fault_vec_q) | mismatch;
        uncorr_d    = (clr_faults ? 1'b0 : uncorr_q) | all_distinct;
    end

    // Replica registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r0_q <= '0;
            r1_q <= '0;
            r2_q <= '0;
        end else begin
            r0_q <= r0_d;
            r1_q <= r1_d;
            r2_q <= r2_d;
        end
    end

    // Fault log registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_vec_q <= '0;
            fault_cnt_q <= '0;
            uncorr_q    <= 1'b0;
        end else begin
            fault_vec_q <= fault_vec_d;
            fault_cnt_q <= fault_cnt_d;
            uncorr_q    <= uncorr_d;
        end
    end

    assign fault_vec     = fault_vec_q;
    assign fault_cnt     = fault_cnt_q;
    assign uncorrectable = uncorr_q;

endmodule

// File: tb/tb_tmr_counter_ctrl.sv
// Directed bench for tmr_counter_ctrl: a full-width wrap instance and a modulus-10 instance.
module tb_tmr_counter_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Full-width instance (WIDTH=64, MODULUS=0).
    logic        en0 = 0, up0 = 0, ld0 = 0, clr0 = 0;
    logic [63:0] lv0 = '0, msk0 = '0;
    logic [2:0]  inj0 = '0;
    logic [63:0] q0;
    logic        tc0, unc0;
    logic [2:0]  mm0, fv0;
    logic [7:0]  fc0;

    // Modulus-10 instance (WIDTH=8).
    logic        en1 = 0, up1 = 0, ld1 = 0, clr1 = 0;
    logic [7:0]  lv1 = '0, msk1 = '0;
    logic [2:0]  inj1 = '0;
    logic [7:0]  q1;
    logic        tc1, unc1;
    logic [2:0]  mm1, fv1;
    logic [7:0]  fc1;

    int tests  = 0;
    int failed = 0;

    tmr_counter_ctrl #(.WIDTH(64), .MODULUS(64'd0), .FCNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .enable(en0), .up(up0), .load(ld0), .load_val(lv0),
        .clr_faults(clr0), .inj(inj0), .inj_mask(msk0), .q_out(q0), .tc(tc0),
        .mismatch(mm0), .fault_vec(fv0), .fault_cnt(fc0), .uncorrectable(unc0)
    );

    tmr_counter_ctrl #(.WIDTH(8), .MODULUS(8'd10), .FCNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .enable(en1), .up(up1), .load(ld1), .load_val(lv1),
        .clr_faults(clr1), .inj(inj1), .inj_mask(msk1), .q_out(q1), .tc(tc1),
        .mismatch(mm1), .fault_vec(fv1), .fault_cnt(fc1), .uncorrectable(unc1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state, sampled after an edge has passed while held in reset.
        #12;
        chk("rst_q0", q0, 64'd0);
        chk("rst_mm0", {61'd0, mm0}, 64'd0);
        chk("rst_fv0", {61'd0, fv0}, 64'd0);
        chk("rst_fc0", {56'd0, fc0}, 64'd0);
        chk("rst_unc0", {63'd0, unc0}, 64'd0);
        chk("rst_q1", {56'd0, q1}, 64'd0);
        en0 = 1; up0 = 0;
        #1;
        chk("rst_tc_down", {63'd0, tc0}, 64'd1);
        up0 = 1;
        #1;
        chk("rst_tc_up", {63'd0, tc0}, 64'd0);
        rst = 1;

        // Count up 1..5 from reset release.
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("count_up", q0, 64'(i));
        end
        chk("count_mm", {61'd0, mm0}, 64'd0);
        chk("count_fc", {56'd0, fc0}, 64'd0);
        en0 = 0;

        // Modulus 10: load 9, wrap up, wrap down, clamp an out-of-range load.
        ld1 = 1; lv1 = 8'd9;
        step();
        chk("m10_load9", {56'd0, q1}, 64'd9);
        ld1 = 0; en1 = 1; up1 = 1;
        #1;
        chk("m10_tc_up", {63'd0, tc1}, 64'd1);
        step();
        chk("m10_wrap_up", {56'd0, q1}, 64'd0);
        up1 = 0;
        #1;
        chk("m10_tc_down", {63'd0, tc1}, 64'd1);
        step();
        chk("m10_wrap_down", {56'd0, q1}, 64'd9);
        step();
        chk("m10_down", {56'd0, q1}, 64'd8);
        en1 = 0; ld1 = 1; lv1 = 8'd15;
        #1;
        chk("m10_tc_load", {63'd0, tc1}, 64'd0);
        step();
        chk("m10_clamp", {56'd0, q1}, 64'd9);
        lv1 = 8'd3;
        step();
        chk("m10_load3", {56'd0, q1}, 64'd3);
        ld1 = 0;

        // Single-replica injection at q=4 while holding.
        ld0 = 1; lv0 = 64'd4;
        step();
        ld0 = 0; inj0 = 3'b010; msk0 = 64'h1;
        step();
        chk("inj_q", q0, 64'd4);
        chk("inj_mm", {61'd0, mm0}, 64'd2);
        chk("inj_fv_early", {61'd0, fv0}, 64'd0);
        inj0 = 3'b000;
        step();
        chk("inj_q_after", q0, 64'd4);
        chk("inj_mm_after", {61'd0, mm0}, 64'd0);
        chk("inj_fv", {61'd0, fv0}, 64'd2);
        chk("inj_fc", {56'd0, fc0}, 64'd1);

        // Three pairwise-distinct replicas: vote is bitwise majority, uncorrectable latches.
        force dut0.r0_q = 64'h3;
        force dut0.r1_q = 64'h5;
        force dut0.r2_q = 64'h6;
        #1;
        chk("tri_q", q0, 64'h7);
        chk("tri_mm", {61'd0, mm0}, 64'd7);
        step();
        chk("tri_unc", {63'd0, unc0}, 64'd1);
        chk("tri_fv", {61'd0, fv0}, 64'd7);
        release dut0.r0_q;
        release dut0.r1_q;
        release dut0.r2_q;
        step();
        step();
        chk("tri_scrub_q", q0, 64'h7);
        chk("tri_scrub_mm", {61'd0, mm0}, 64'd0);

        // Clear concurrent with a fresh replica-2 event: only the new event survives.
        inj0 = 3'b100; msk0 = 64'h1;
        step();
        chk("clr_mm", {61'd0, mm0}, 64'd4);
        inj0 = 3'b000; clr0 = 1;
        step();
        clr0 = 0;
        chk("clr_fv", {61'd0, fv0}, 64'd4);
        chk("clr_fc", {56'd0, fc0}, 64'd1);
        chk("clr_unc", {63'd0, unc0}, 64'd0);

        // Continuous replica-0 injection while counting: counter saturates, count stays right.
        en0 = 1; up0 = 1; inj0 = 3'b001; msk0 = 64'hFF;
        for (int i = 1; i <= 261; i++) begin
            step();
            chk("sat_q", q0, 64'(7 + i));
        end
        chk("sat_mm", {61'd0, mm0}, 64'd1);
        chk("sat_fc", {56'd0, fc0}, 64'd255);
        chk("sat_fv", {61'd0, fv0}, 64'd5);

        // Asynchronous reset mid-count with injection still active.
        #2;
        rst = 0;
        #1;
        chk("arst_q", q0, 64'd0);
        chk("arst_mm", {61'd0, mm0}, 64'd0);
        chk("arst_fv", {61'd0, fv0}, 64'd0);
        chk("arst_fc", {56'd0, fc0}, 64'd0);
        chk("arst_unc", {63'd0, unc0}, 64'd0);
        step();
        chk("arst_hold_q", q0, 64'd0);
        chk("arst_hold_fc", {56'd0, fc0}, 64'd0);
        inj0 = 3'b000;
        #2;
        rst = 1;
        step();
        chk("resume_q", q0, 64'd1);
        step();
        chk("resume_q2", q0, 64'd2);
        chk("resume_fc", {56'd0, fc0}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
